decoder_scan_seq: RTL and testbench

Upstream select sequencer for the 3-to-8 decoder stage. It generates the 3-bit select {a,b,c} that drives the decoder's a/b/c inputs. On each start it walks the non-skipped codes in ascending order, holding each code for a programmable dwell time. It runs either a single pass or loops continuously, and reports progress through `busy`, `sel_valid`, a pass-complete pulse and a pass counter.

---
 rtl/decoder_scan_seq.sv | 143 ++++++++++++++
 tb/tb_decoder_scan_seq.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_seq.sv
// decoder_scan_seq: walks the unskipped 3-bit codes in ascending order,
// holding each for DWELL cycles, to drive the a/b/c selects of a 3-to-8 decoder.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, stop       begin a scan (IDLE only) / abort to IDLE (wins over start)
//   mode              0 = continuous loop, 1 = single pass (latched at start)
//   skip_mask         bit k set skips code k (latched at start)
//   a, b, c           select code {a,b,c}, a is the MSB
//   sel_valid, busy   a/b/c live, FSM not in IDLE
//   pass_done         one-cycle pulse after the last hold cycle of a pass
//   pass_count        completed passes since the last start, wraps at 255
module decoder_scan_seq #(
   parameter int DWELL = 4,
   parameter int DW    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       mode,
   input  logic [7:0] skip_mask,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       sel_valid,
   output logic       busy,
   output logic       pass_done,
   output logic [7:0] pass_count
);

   // A DWELL of 0 behaves like 1, so the last hold cycle is count 0.
   localparam int            LAST_I = (DWELL <= 1) ? 0 : DWELL - 1;
   localparam logic [DW-1:0] LAST   = LAST_I[DW-1:0];

   typedef enum logic {
      IDLE,
      HOLD
   } state_t;

   state_t        state;
   logic [2:0]    code;
   logic [DW-1:0] cnt;
   logic [7:0]    mask_q;
   logic          mode_q;

   logic [3:0]    nxt;
   logic [2:0]    lo_q;
   logic [2:0]    lo_in;

   // Lowest code whose skip bit is clear (caller guarantees one exists).
   function automatic logic [2:0] first_code(input logic [7:0] m);
      logic [2:0] r;
      r = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (!m[k]) r = k[2:0];
      end
      return r;
   endfunction

   // {found, code}: lowest unskipped code strictly above cur.
   function automatic logic [3:0] next_code(input logic [7:0] m,
                                            input logic [2:0] cur);
      logic [3:0] r;
      r = 4'd0;
      for (int k = 7; k >= 0; k--) begin
         if (k > int'(cur) && !m[k]) r = {1'b1, k[2:0]};
      end
      return r;
   endfunction

   always_comb begin
      nxt   = next_code(mask_q, code);
      lo_q  = first_code(mask_q);
      lo_in = first_code(skip_mask);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         code       <= 3'd0;
         cnt        <= '0;
         mask_q     <= 8'd0;
         mode_q     <= 1'b0;
         sel_valid  <= 1'b0;
         busy       <= 1'b0;
         pass_done  <= 1'b0;
         pass_count <= 8'd0;
      end else begin
         pass_done <= 1'b0;
         if (stop) begin
            state     <= IDLE;
            code      <= 3'd0;
            cnt       <= '0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start && skip_mask != 8'hFF) begin
                     mask_q     <= skip_mask;
                     mode_q     <= mode;
                     pass_count <= 8'd0;
                     code       <= lo_in;
                     cnt        <= '0;
                     sel_valid  <= 1'b1;
                     busy       <= 1'b1;
                     state      <= HOLD;
                  end
               end
               HOLD: begin
                  if (cnt == LAST) begin
                     cnt <= '0;
                     if (nxt[3]) begin
                        code <= nxt[2:0];
                     end else begin
                        // End of pass: wrap or finish.
                        pass_count <= pass_count + 8'd1;
                        pass_done  <= 1'b1;
                        if (mode_q) begin
                           state     <= IDLE;
                           code      <= 3'd0;
                           sel_valid <= 1'b0;
                           busy      <= 1'b0;
                        end else begin
                           code <= lo_q;
                        end
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign a = code[2];
   assign b = code[1];
   assign c = code[0];

endmodule

// File: tb/tb_decoder_scan_seq.sv
// tb_decoder_scan_seq: randomized and directed bench for decoder_scan_seq.
// Two instances (DWELL=4 and DWELL=1) share stimulus; each has its own model.
module tb_decoder_scan_seq;

   logic       clk = 1'b0;
   logic       rst, start, stop, mode;
   logic [7:0] skip_mask;

   logic       a4, b4, c4, v4, bz4, pd4;
   logic [7:0] pc4;
   logic       a1, b1, c1, v1, bz1, pd1;
   logic [7:0] pc1;

   always #5 clk = ~clk;

   decoder_scan_seq #(.DWELL(4), .DW(8)) dut4 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
      .skip_mask(skip_mask), .a(a4), .b(b4), .c(c4), .sel_valid(v4),
      .busy(bz4), .pass_done(pd4), .pass_count(pc4)
   );

   decoder_scan_seq #(.DWELL(1), .DW(8)) dut1 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
      .skip_mask(skip_mask), .a(a1), .b(b1), .c(c1), .sel_valid(v1),
      .busy(bz1), .pass_done(pd1), .pass_count(pc1)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Model: a run is the ordered list of unskipped codes, t counts
   // cycles since the first valid cycle.
   int       dw[2] = '{4, 1};
   bit       m_run[2];
   int       m_t[2];
   bit [7:0] m_pc[2];
   bit       m_pd[2];
   bit       m_mode[2];
   int       m_n[2];
   bit [2:0] m_list[2][8];

   task automatic tick();
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_run[i] = 0; m_pc[i] = 0; m_pd[i] = 0;
         end else if (stop) begin
            m_run[i] = 0; m_pd[i] = 0;
         end else if (!m_run[i]) begin
            m_pd[i] = 0;
            if (start && skip_mask != 8'hFF) begin
               m_n[i] = 0;
               for (int k = 0; k < 8; k++)
                  if (!skip_mask[k]) begin
                     m_list[i][m_n[i]] = k[2:0];
                     m_n[i]++;
                  end
               m_run[i] = 1; m_t[i] = 0; m_pc[i] = 0; m_mode[i] = mode;
            end
         end else begin
            m_t[i]++;
            if (m_t[i] % (m_n[i] * dw[i]) == 0) begin
               m_pc[i]++;
               m_pd[i] = 1;
               if (m_mode[i]) m_run[i] = 0;
            end else begin
               m_pd[i] = 0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [12:0] exp_vec(input int i);
      logic [2:0] cd;
      cd = m_run[i] ? m_list[i][(m_t[i] / dw[i]) % m_n[i]] : 3'd0;
      return {m_run[i], m_run[i], cd, m_pd[i], m_pc[i]};
   endfunction

   function automatic logic [12:0] obs_vec(input int i);
      if (i == 0) return {bz4, v4, a4, b4, c4, pd4, pc4};
      return {bz1, v1, a1, b1, c1, pd1, pc1};
   endfunction

   task automatic test_reset();
      rst = 1; start = 0; stop = 0; mode = 0; skip_mask = 8'h00;
      tick(); tick();
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (obs_vec(i) !== 13'd0) begin
            n_bad++;
            $display("FAIL reset dut%0d got %h want 0", i, obs_vec(i));
         end
      end
      rst = 0;
      tick();
   endtask

   task automatic test_full_pass();
      int vcnt = 0;
      skip_mask = 8'h00; mode = 1; start = 1;
      tick();
      start = 0;
      for (int t = 0; t < 40; t++) begin
         if (v4) vcnt++;
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs_vec(i) !== exp_vec(i)) begin
               n_bad++;
               $display("FAIL full_pass dut%0d t=%0d got %h want %h",
                        i, t, obs_vec(i), exp_vec(i));
            end
         end
         tick();
      end
      n_cmp++;
      if (vcnt != 32) begin
         n_bad++;
         $display("FAIL full_pass_valid_cycles got %0d want 32", vcnt);
      end
   endtask

   task automatic test_skip_pattern();
      int seq[$];
      int want[4] = '{1, 3, 4, 6};
      skip_mask = 8'b1010_0101; mode = 1; start = 1;
      tick();
      start = 0;
      for (int t = 0; t < 24; t++) begin
         if (v4 && (seq.size() == 0 || seq[$] != int'({a4, b4, c4})))
            seq.push_back(int'({a4, b4, c4}));
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs_vec(i) !== exp_vec(i)) begin
               n_bad++;
               $display("FAIL skip dut%0d t=%0d got %h want %h",
                        i, t, obs_vec(i), exp_vec(i));
            end
         end
         tick();
      end
      n_cmp++;
      if (seq.size() != 4) begin
         n_bad++;
         $display("FAIL skip_seq_len got %0d want 4", seq.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (seq[k] != want[k]) begin
               n_bad++;
               $display("FAIL skip_seq[%0d] got %0d want %0d",
                        k, seq[k], want[k]);
            end
         end
      end
   endtask

   task automatic test_single_code_wrap();
      bit wrap = 0;
      bit saw10 = 0;
      logic [7:0] prev;
      skip_mask = 8'hFE; mode = 0; start = 1;
      tick();
      start = 0;
      prev = pc1;
      for (int t = 0; t < 300; t++) begin
         if (prev == 8'd255 && pc1 == 8'd0) wrap = 1;
         if (pc1 == 8'd10) saw10 = 1;
         prev = pc1;
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs_vec(i) !== exp_vec(i)) begin
               n_bad++;
               $display("FAIL wrap dut%0d t=%0d got %h want %h",
                        i, t, obs_vec(i), exp_vec(i));
            end
         end
         tick();
      end
      n_cmp++;
      if (!wrap || !saw10) begin
         n_bad++;
         $display("FAIL wrap_seen got %0b%0b want 11", wrap, saw10);
      end
      stop = 1;
      tick();
      stop = 0;
   endtask

   task automatic test_all_skipped();
      skip_mask = 8'hFF; mode = 1; start = 1;
      tick();
      for (int t = 0; t < 4; t++) begin
         n_cmp++;
         if ({bz4, v4, a4, b4, c4} !== 5'd0) begin
            n_bad++;
            $display("FAIL all_skipped t=%0d got %b want 0",
                     t, {bz4, v4, a4, b4, c4});
         end
         tick();
      end
      start = 0;
   endtask

   task automatic test_stop_mid();
      skip_mask = 8'h00; mode = 0; start = 1;
      tick();
      start = 0;
      repeat (22) tick();
      n_cmp++;
      if ({a4, b4, c4} !== 3'd5) begin
         n_bad++;
         $display("FAIL stop_pos got %0d want 5", {a4, b4, c4});
      end
      stop = 1; start = 1;
      for (int t = 0; t < 3; t++) begin
         tick();
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs_vec(i) !== exp_vec(i)) begin
               n_bad++;
               $display("FAIL stop_mid dut%0d t=%0d got %h want %h",
                        i, t, obs_vec(i), exp_vec(i));
            end
         end
         stop = 0; start = 0;
      end
      n_cmp++;
      if (pc1 !== 8'd2) begin
         n_bad++;
         $display("FAIL stop_keeps_count got %0d want 2", pc1);
      end
   endtask

   task automatic test_rst_and_mask_change();
      skip_mask = 8'h00; mode = 1; start = 1;
      tick();
      start = 0;
      repeat (5) tick();
      skip_mask = 8'hAA; mode = 0;
      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs_vec(i) !== exp_vec(i)) begin
               n_bad++;
               $display("FAIL mask_hold dut%0d t=%0d got %h want %h",
                        i, t, obs_vec(i), exp_vec(i));
            end
         end
         tick();
      end
      rst = 1;
      tick();
      rst = 0;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (obs_vec(i) !== 13'd0) begin
            n_bad++;
            $display("FAIL rst_mid dut%0d got %h want 0", i, obs_vec(i));
         end
      end
   endtask

   task automatic test_back_to_back();
      skip_mask = 8'h3C; mode = 1; start = 1;
      for (int t = 0; t < 60; t++) begin
         tick();
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs_vec(i) !== exp_vec(i)) begin
               n_bad++;
               $display("FAIL back_to_back dut%0d t=%0d got %h want %h",
                        i, t, obs_vec(i), exp_vec(i));
            end
         end
      end
      start = 0; stop = 1;
      tick();
      stop = 0;
   endtask

   task automatic test_random();
      for (int t = 0; t < 3000; t++) begin
         start = ($urandom_range(3) == 0);
         stop  = ($urandom_range(39) == 0);
         rst   = ($urandom_range(199) == 0);
         mode  = 1'($urandom_range(1));
         skip_mask = ($urandom_range(15) == 0) ? 8'hFF : 8'($urandom);
         tick();
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs_vec(i) !== exp_vec(i)) begin
               n_bad++;
               $display("FAIL random dut%0d t=%0d got %h want %h",
                        i, t, obs_vec(i), exp_vec(i));
            end
         end
      end
      rst = 0; start = 0; stop = 0;
   endtask

   initial begin
      test_reset();
      test_full_pass();
      test_skip_pattern();
      test_single_code_wrap();
      test_all_skipped();
      test_stop_mid();
      test_rst_and_mask_change();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
